// File: rtl/carry4_addsub_sched.sv
`default_nettype none
// ============================================================================
// Module   : carry4_addsub_sched
// Purpose  : Two-requester add/subtract over one shared 4-bit carry slice,
//            round-robin arbitrated, one nibble per cycle.
// Revision : 1.0
// ============================================================================
module carry4_addsub_sched #(
  parameter int CHUNKS = 4,
  localparam int W     = 4 * CHUNKS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [W-1:0] req_a0,
  input  logic [W-1:0] req_b0,
  input  logic         req_sub0,
  input  logic [W-1:0] req_a1,
  input  logic [W-1:0] req_b1,
  input  logic         req_sub1,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_sum,
  output logic         res_cout,
  output logic         res_ovf,
  output logic         res_id,
  output logic         busy
);

  localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]       r_state;
  logic             r_last_grant;
  logic [IDX_W-1:0] r_idx;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic             r_carry;
  logic [W-1:0]     r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_id;

  logic             w_grant;
  logic             w_accept;
  logic [W-1:0]     w_sel_a;
  logic [W-1:0]     w_sel_b;
  logic             w_sel_sub;
  logic [IDX_W+1:0] w_base;
  logic [3:0]       w_s;
  logic [3:0]       w_di;
  logic [3:0]       w_o;
  logic             w_c1, w_c2, w_c3, w_c4;
  logic             w_last;

  // Contention goes to whoever was not served last; otherwise the sole valid one.
  always_comb begin
    w_grant   = (&req_valid) ? ~r_last_grant : req_valid[1];
    req_ready = (r_state == c_IDLE) ? (req_valid & (w_grant ? 2'b10 : 2'b01)) : 2'b00;
    w_accept  = |req_ready;
    w_sel_a   = w_grant ? req_a1   : req_a0;
    w_sel_b   = w_grant ? req_b1   : req_b0;
    w_sel_sub = w_grant ? req_sub1 : req_sub0;
  end

  // CARRY4-style slice: mux chain selected by propagate, XOR for the sum.
  always_comb begin
    w_base = {r_idx, 2'b00};
    w_di   = r_a[w_base +: 4];
    w_s    = w_di ^ r_b[w_base +: 4];
    w_c1   = w_s[0] ? r_carry : w_di[0];
    w_c2   = w_s[1] ? w_c1    : w_di[1];
    w_c3   = w_s[2] ? w_c2    : w_di[2];
    w_c4   = w_s[3] ? w_c3    : w_di[3];
    w_o    = w_s ^ {w_c3, w_c2, w_c1, r_carry};
    w_last = (r_idx == IDX_W'(CHUNKS - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= c_IDLE;
      r_last_grant <= 1'b1;
      r_idx        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_carry      <= 1'b0;
      r_sum        <= '0;
      r_cout       <= 1'b0;
      r_ovf        <= 1'b0;
      r_id         <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_a          <= w_sel_a;
            r_b          <= w_sel_sub ? ~w_sel_b : w_sel_b;
            r_carry      <= w_sel_sub;
            r_idx        <= '0;
            r_id         <= w_grant;
            r_last_grant <= w_grant;
            r_state      <= c_RUN;
          end
        end
        c_RUN: begin
          r_sum[w_base +: 4] <= w_o;
          r_carry            <= w_c4;
          if (w_last) begin
            r_cout  <= w_c4;
            r_ovf   <= w_c3 ^ w_c4;
            r_state <= c_DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        c_DONE: begin
          if (res_ready) r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign res_valid = (r_state == c_DONE);
  assign busy      = (r_state != c_IDLE);
  assign res_sum   = r_sum;
  assign res_cout  = r_cout;
  assign res_ovf   = r_ovf;
  assign res_id    = r_id;

endmodule
`default_nettype wire

// File: tb/tb_carry4_addsub_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_carry4_addsub_sched
// Purpose  : Randomized and directed self-checking bench for carry4_addsub_sched.
// Revision : 1.0
// ============================================================================
module tb_carry4_addsub_sched;

  localparam int CHUNKS = 4;
  localparam int W      = 4 * CHUNKS;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [W-1:0] req_a0, req_b0, req_a1, req_b1;
  logic         req_sub0, req_sub1;
  logic         res_valid, res_ready;
  logic [W-1:0] res_sum;
  logic         res_cout, res_ovf, res_id, busy;

  int total = 0;
  int bad   = 0;

  carry4_addsub_sched #(.CHUNKS(CHUNKS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_sub0(req_sub0),
    .req_a1(req_a1), .req_b1(req_b1), .req_sub1(req_sub1),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_cout(res_cout), .res_ovf(res_ovf),
    .res_id(res_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: {ovf, cout, sum} from plain unsigned/signed arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic [W-1:0] s;
    logic         c, v;
    logic [W:0]   wide;
    if (sub) begin
      s = a - b;
      c = (a >= b);
      v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
    end else begin
      wide = {1'b0, a} + {1'b0, b};
      s = wide[W-1:0];
      c = wide[W];
      v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    end
    return {v, c, s};
  endfunction

  task automatic do_reset();
    rst = 1'b1; req_valid = 2'b00; res_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Issues one request, scrambles the operands after accept, waits for the result.
  task automatic run_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        output logic [W-1:0] sum, output logic cout, output logic ovf,
                        output logic rid, output int lat, output logic acc);
    @(negedge clk);
    res_ready = 1'b1;
    if (id) begin req_a1 = a; req_b1 = b; req_sub1 = sub; end
    else    begin req_a0 = a; req_b0 = b; req_sub0 = sub; end
    req_valid = id ? 2'b10 : 2'b01;
    #1;
    acc = (req_ready == req_valid);
    @(negedge clk);
    req_valid = 2'b00;
    req_a0 = W'($urandom); req_b0 = W'($urandom); req_sub0 = 1'($urandom);
    req_a1 = W'($urandom); req_b1 = W'($urandom); req_sub1 = 1'($urandom);
    lat = 0;
    while (!res_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    sum = res_sum; cout = res_cout; ovf = res_ovf; rid = res_id;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b00; res_ready = 1'b0;
    @(negedge clk); #1;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
    total++; if (res_sum !== '0) begin bad++; $display("FAIL reset_res_sum got=%h exp=0", res_sum); end
    total++; if ({res_cout, res_ovf, res_id} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {res_cout, res_ovf, res_id}); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
    rst = 1'b0;
    @(negedge clk); #1;
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL idle_noreq_ready got=%b exp=00", req_ready); end
  endtask

  task automatic test_directed();
    logic [W-1:0] av [5] = '{16'h00FF, 16'hFFFF, 16'h0005, 16'h8000, 16'h7FFF};
    logic [W-1:0] bv [5] = '{16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0001};
    logic         sv [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [W-1:0] sum; logic cout, ovf, rid, acc; int lat;
    logic [W+1:0] exp;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_op(1'b0, av[i], bv[i], sv[i], sum, cout, ovf, rid, lat, acc);
      exp = model(av[i], bv[i], sv[i]);
      total++; if (acc !== 1'b1) begin bad++; $display("FAIL dir%0d_accept got=%b exp=1", i, acc); end
      total++; if (lat != CHUNKS) begin bad++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, CHUNKS); end
      total++; if ({ovf, cout, sum} !== exp) begin bad++; $display("FAIL dir%0d_result got=%b/%b/%h exp=%b/%b/%h", i, ovf, cout, sum, exp[W+1], exp[W], exp[W-1:0]); end
      total++; if (rid !== 1'b0) begin bad++; $display("FAIL dir%0d_id got=%b exp=0", i, rid); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, sum; logic sub, id, cout, ovf, rid, acc; int lat;
    logic [W+1:0] exp;
    for (int i = 0; i < 30; i++) begin
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom); id = 1'($urandom);
      if (i % 7 == 0) b = W'(1) - W'(a);
      run_op(id, a, b, sub, sum, cout, ovf, rid, lat, acc);
      exp = model(a, b, sub);
      total++; if (acc !== 1'b1 || lat != CHUNKS) begin bad++; $display("FAIL rnd%0d_timing acc=%b lat=%0d exp lat=%0d", i, acc, lat, CHUNKS); end
      total++; if ({ovf, cout, sum} !== exp || rid !== id) begin bad++; $display("FAIL rnd%0d_result a=%h b=%h sub=%b got=%b/%b/%h id=%b exp=%b/%b/%h id=%b", i, a, b, sub, ovf, cout, sum, rid, exp[W+1], exp[W], exp[W-1:0], id); end
      total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rnd%0d_valid_drop got=%b exp=0", i, res_valid); end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] exp_sum; int n;
    exp_sum = 16'h159D;
    do_reset();
    res_ready = 1'b0;
    req_a0 = 16'h1357; req_b0 = 16'h0246; req_sub0 = 1'b0;
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    n = 0;
    while (!res_valid && n < 50) begin @(negedge clk); n++; end
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL bp_wait_valid got=%b exp=1", res_valid); end
    req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (res_valid !== 1'b1 || res_sum !== exp_sum || res_id !== 1'b0 || req_ready !== 2'b00 || busy !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold%0d got v=%b sum=%h id=%b rdy=%b busy=%b exp v=1 sum=%h id=0 rdy=00 busy=1", i, res_valid, res_sum, res_id, req_ready, busy, exp_sum);
      end
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk); #1;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b exp=0", res_valid); end
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL bp_next_grant got=%b exp=10", req_ready); end
    req_valid = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_arbitration();
    int   gcyc [4];
    logic gid  [4];
    int   ng;
    do_reset();
    res_ready = 1'b1;
    req_a0 = W'($urandom); req_b0 = W'($urandom); req_sub0 = 1'b0;
    req_a1 = W'($urandom); req_b1 = W'($urandom); req_sub1 = 1'b1;
    req_valid = 2'b11;
    ng = 0;
    for (int cyc = 0; cyc < 80 && ng < 4; cyc++) begin
      #1;
      if (req_ready != 2'b00) begin
        total++; if ($countones(req_ready) != 1) begin bad++; $display("FAIL arb_onehot got=%b exp one bit", req_ready); end
        gid[ng] = req_ready[1]; gcyc[ng] = cyc; ng++;
      end
      if (res_valid && ng > 0) begin
        total++; if (res_id !== gid[ng-1]) begin bad++; $display("FAIL arb_res_id got=%b exp=%b", res_id, gid[ng-1]); end
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    total++; if (ng != 4) begin bad++; $display("FAIL arb_grant_count got=%0d exp=4", ng); end
    for (int i = 0; i < ng; i++) begin
      total++; if (gid[i] !== 1'(i % 2)) begin bad++; $display("FAIL arb_order%0d got=%b exp=%0d", i, gid[i], i % 2); end
      if (i > 0) begin
        total++; if (gcyc[i] - gcyc[i-1] != CHUNKS + 2) begin bad++; $display("FAIL arb_spacing%0d got=%0d exp=%0d", i, gcyc[i] - gcyc[i-1], CHUNKS + 2); end
      end
    end
    @(negedge clk); @(negedge clk); @(negedge clk); @(negedge clk); @(negedge clk); @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    res_ready = 1'b1;
    req_a1 = 16'h1234; req_b1 = 16'h1111; req_sub1 = 1'b0;
    req_valid = 2'b10;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk); @(negedge clk);
    #1;
    total++; if (res_sum === '0 || busy !== 1'b1) begin bad++; $display("FAIL mid_progress sum=%h busy=%b exp nonzero sum busy=1", res_sum, busy); end
    rst = 1'b1;
    #1;
    total++;
    if (res_valid !== 1'b0 || res_sum !== '0 || res_cout !== 1'b0 || res_ovf !== 1'b0 || res_id !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_outputs got v=%b sum=%h c=%b o=%b id=%b busy=%b exp all 0", res_valid, res_sum, res_cout, res_ovf, res_id, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      total++; if (res_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_stale%0d v=%b busy=%b exp 0/0", i, res_valid, busy); end
    end
    req_valid = 2'b11;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL mid_first_grant got=%b exp=01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b00; res_ready = 1'b0;
    req_a0 = '0; req_b0 = '0; req_sub0 = 1'b0;
    req_a1 = '0; req_b1 = '0; req_sub1 = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_arbitration();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
